// File: rtl/tcp_tx_pkg.sv
// rtl/tcp_tx_pkg.sv - shared states, status codes and field slices for the TCP TX session controller
package tcp_tx_pkg;

  typedef enum logic [1:0] {
    L_WAIT,
    L_REQ,
    L_STAT,
    L_DONE
  } listen_state_t;

  typedef enum logic [2:0] {
    IDLE,
    META,
    STATUS,
    BACKOFF,
    DATA,
    DROP
  } tx_state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_NOCONN  = 2'd1;
  localparam logic [1:0] ST_NOSPACE = 2'd2;

  localparam int META_SESSION_LSB = 0;
  localparam int META_SESSION_MSB = 15;
  localparam int META_LENGTH_LSB  = 16;
  localparam int META_LENGTH_MSB  = 31;

  localparam int STATUS_CODE_LSB = 62;
  localparam int STATUS_CODE_MSB = 63;

endpackage

// File: rtl/tcp_tx_session_ctrl_listen_opener.sv
// rtl/tcp_tx_session_ctrl_listen_opener.sv - opens NUM_PORTS consecutive listen ports with delay and retry
module tcp_listen_opener
  import tcp_tx_pkg::*;
#(
  parameter int          NUM_PORTS       = 1,
  parameter logic [15:0] BASE_PORT       = 16'd2888,
  parameter int          OPEN_DELAY_BITS = 16
) (
  input  logic        clk,
  input  logic        aresetn,
  output logic        m_listen_valid,
  input  logic        m_listen_ready,
  output logic [15:0] m_listen_data,
  input  logic        s_listen_status_valid,
  output logic        s_listen_status_ready,
  input  logic [7:0]  s_listen_status_data,
  output logic        listen_done
);

  localparam int IDX_W = 5;

  listen_state_t              state_q, state_d;
  logic [OPEN_DELAY_BITS-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       valid_q, valid_d;
  logic [15:0]                port_q, port_d;
  logic                       unused_status_bits;

  assign unused_status_bits    = ^s_listen_status_data[7:1];
  assign m_listen_valid        = valid_q;
  assign m_listen_data         = port_q;
  assign s_listen_status_ready = (state_q == L_STAT);
  assign listen_done           = (state_q == L_DONE);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q <= L_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      port_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      port_q  <= port_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    port_d  = port_q;
    case (state_q)
      L_WAIT: begin
        if (cnt_q[OPEN_DELAY_BITS-1]) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          port_d  = BASE_PORT + 16'(idx_q);
          state_d = L_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      L_REQ: begin
        if (m_listen_ready) begin
          valid_d = 1'b0;
          state_d = L_STAT;
        end
      end
      L_STAT: begin
        // A refused port keeps idx so the same port is retried after the delay.
        if (s_listen_status_valid) begin
          if (s_listen_status_data[0]) begin
            if (idx_q == IDX_W'(NUM_PORTS - 1)) begin
              state_d = L_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = L_WAIT;
            end
          end else begin
            state_d = L_WAIT;
          end
        end
      end
      L_DONE:  state_d = L_DONE;
      default: state_d = L_WAIT;
    endcase
  end

endmodule

// File: rtl/tcp_tx_session_ctrl.sv
// rtl/tcp_tx_session_ctrl.sv - TX session controller: listen opening, metadata/status handshake, forward/drop/retry
module tcp_tx_session_ctrl
  import tcp_tx_pkg::*;
#(
  parameter int          DATA_WIDTH      = 512,
  parameter int          NUM_PORTS       = 1,
  parameter logic [15:0] BASE_PORT       = 16'd2888,
  parameter int          OPEN_DELAY_BITS = 16,
  parameter int          RETRY_CYCLES    = 1024,
  parameter int          MAX_RETRIES     = 4
) (
  input  logic                    clk,
  input  logic                    aresetn,
  output logic                    m_listen_valid,
  input  logic                    m_listen_ready,
  output logic [15:0]             m_listen_data,
  input  logic                    s_listen_status_valid,
  output logic                    s_listen_status_ready,
  input  logic [7:0]              s_listen_status_data,
  output logic                    listen_done,
  input  logic                    s_meta_valid,
  output logic                    s_meta_ready,
  input  logic [31:0]             s_meta_data,
  input  logic                    s_data_valid,
  output logic                    s_data_ready,
  input  logic [DATA_WIDTH-1:0]   s_data_data,
  input  logic [DATA_WIDTH/8-1:0] s_data_keep,
  input  logic                    s_data_last,
  output logic                    m_txmeta_valid,
  input  logic                    m_txmeta_ready,
  output logic [31:0]             m_txmeta_data,
  input  logic                    s_txstatus_valid,
  output logic                    s_txstatus_ready,
  input  logic [63:0]             s_txstatus_data,
  output logic                    m_tx_valid,
  input  logic                    m_tx_ready,
  output logic [DATA_WIDTH-1:0]   m_tx_data,
  output logic [DATA_WIDTH/8-1:0] m_tx_keep,
  output logic                    m_tx_last,
  output logic [31:0]             pkts_sent,
  output logic [31:0]             pkts_dropped
);

  localparam int BO_W = $clog2(RETRY_CYCLES + 1);

  tcp_listen_opener #(
    .NUM_PORTS      (NUM_PORTS),
    .BASE_PORT      (BASE_PORT),
    .OPEN_DELAY_BITS(OPEN_DELAY_BITS)
  ) u_listen (
    .clk                  (clk),
    .aresetn              (aresetn),
    .m_listen_valid       (m_listen_valid),
    .m_listen_ready       (m_listen_ready),
    .m_listen_data        (m_listen_data),
    .s_listen_status_valid(s_listen_status_valid),
    .s_listen_status_ready(s_listen_status_ready),
    .s_listen_status_data (s_listen_status_data),
    .listen_done          (listen_done)
  );

  tx_state_t        state_q, state_d;
  logic [31:0]      meta_q, meta_d;
  logic             txmeta_valid_q, txmeta_valid_d;
  logic [7:0]       retry_q, retry_d;
  logic [BO_W-1:0]  bo_q, bo_d;
  logic [31:0]      sent_q, sent_d;
  logic [31:0]      dropped_q, dropped_d;
  logic [1:0]       status_code;
  logic             unused_status_bits;

  assign status_code        = s_txstatus_data[STATUS_CODE_MSB:STATUS_CODE_LSB];
  assign unused_status_bits = ^s_txstatus_data[STATUS_CODE_LSB-1:0];
  assign m_txmeta_valid     = txmeta_valid_q;
  assign m_txmeta_data      = meta_q;
  assign pkts_sent          = sent_q;
  assign pkts_dropped       = dropped_q;
  // Beats pass straight through; only valid/ready are gated by state.
  assign m_tx_data          = s_data_data;
  assign m_tx_keep          = s_data_keep;
  assign m_tx_last          = s_data_last;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q        <= IDLE;
      meta_q         <= '0;
      txmeta_valid_q <= 1'b0;
      retry_q        <= '0;
      bo_q           <= '0;
      sent_q         <= '0;
      dropped_q      <= '0;
    end else begin
      state_q        <= state_d;
      meta_q         <= meta_d;
      txmeta_valid_q <= txmeta_valid_d;
      retry_q        <= retry_d;
      bo_q           <= bo_d;
      sent_q         <= sent_d;
      dropped_q      <= dropped_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    meta_d           = meta_q;
    txmeta_valid_d   = txmeta_valid_q;
    retry_d          = retry_q;
    bo_d             = bo_q;
    sent_d           = sent_q;
    dropped_d        = dropped_q;
    s_meta_ready     = 1'b0;
    s_txstatus_ready = 1'b0;
    s_data_ready     = 1'b0;
    m_tx_valid       = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_meta_valid) begin
          s_meta_ready   = 1'b1;
          meta_d         = {s_meta_data[META_LENGTH_MSB:META_LENGTH_LSB],
                            s_meta_data[META_SESSION_MSB:META_SESSION_LSB]};
          retry_d        = '0;
          txmeta_valid_d = 1'b1;
          state_d        = META;
        end
      end
      META: begin
        if (m_txmeta_ready) begin
          txmeta_valid_d = 1'b0;
          state_d        = STATUS;
        end
      end
      STATUS: begin
        s_txstatus_ready = 1'b1;
        if (s_txstatus_valid) begin
          case (status_code)
            ST_OK:     state_d = DATA;
            ST_NOCONN: state_d = DROP;
            ST_NOSPACE: begin
              if (retry_q < 8'(MAX_RETRIES)) begin
                retry_d = retry_q + 1'b1;
                bo_d    = '0;
                state_d = BACKOFF;
              end else begin
                state_d = DROP;
              end
            end
            default:   state_d = DROP;
          endcase
        end
      end
      BACKOFF: begin
        if (bo_q == BO_W'(RETRY_CYCLES - 1)) begin
          txmeta_valid_d = 1'b1;
          state_d        = META;
        end else begin
          bo_d = bo_q + 1'b1;
        end
      end
      DATA: begin
        m_tx_valid   = s_data_valid;
        s_data_ready = m_tx_ready;
        if (s_data_valid && m_tx_ready && s_data_last) begin
          sent_d  = sent_q + 1'b1;
          state_d = IDLE;
        end
      end
      DROP: begin
        s_data_ready = 1'b1;
        if (s_data_valid && s_data_last) begin
          dropped_d = dropped_q + 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/tcp_tx_session_ctrl.md
# tcp_tx_session_ctrl

Parametrised TX-side session controller for the 100G TCP/IP user kernel, sitting between the application result path and the TOE TX interfaces. It opens NUM_PORTS consecutive listen ports at start-up, with retry on failure. For each queued packet it issues tx_metadata, waits for tx_status, then forwards, drops or retries the packet based on the status code. It replaces the fixed single-port, fixed-64-byte, no-retry handshake.

## Interface
Parameters:
- DATA_WIDTH, 512: TX data beat width; KEEP width is DATA_WIDTH/8.
- NUM_PORTS, 1: listen ports to open, range 1..16.
- BASE_PORT, 16'd2888: first port; port i = BASE_PORT+i.
- OPEN_DELAY_BITS, 16: counter width; a listen request fires when bit MSB of the counter is set.
- RETRY_CYCLES, 1024: back-off after a "no space" status.
- MAX_RETRIES, 4: metadata resends before the packet is dropped.

Ports:
- clk in 1: clock (already decided).
- aresetn in 1: reset, synchronous, active-low (already decided).
- m_listen_valid/ready/data out/in/out 1/1/16: listen-port request.
- s_listen_status_valid/ready/data in/out/in 1/1/8: bit0 = 1 means opened.
- listen_done out 1: all ports open.
- s_meta_valid/ready/data in/out/in 1/1/32: {length[31:16], session[15:0]}.
- s_data_valid/ready/data/keep/last in/out/in/in/in 1/1/DATA_WIDTH/DATA_WIDTH/8/1: packet beats, one packet per meta word, same order.
- m_txmeta_valid/ready/data out/in/out 1/1/32: {length, session}.
- s_txstatus_valid/ready/data in/out/in 1/1/64: [63:62] error code.
- m_tx_valid/ready/data/keep/last out/in/out/out/out 1/1/DATA_WIDTH/DATA_WIDTH/8/1: TX data to the TOE.
- pkts_sent, pkts_dropped out 32 each: wrap-around counters.

## Operation
- Listen FSM states: L_WAIT, L_REQ, L_STAT, L_DONE.
  - L_WAIT: count until the counter MSB is set, then clear the counter and go to L_REQ.
  - L_REQ: hold m_listen_valid with data BASE_PORT+idx until ready is seen.
  - L_STAT: s_listen_status_ready=1. On bit0=1, increment idx; go to L_DONE if idx==NUM_PORTS-1, else L_WAIT. On bit0=0, go to L_WAIT with idx unchanged (retry the same port).
  - L_DONE is terminal until reset; listen_done=1 only in L_DONE.
- TX FSM states: IDLE, META, STATUS, BACKOFF, DATA, DROP. The TX FSM runs independently of the listen FSM.
  - IDLE: when s_meta_valid, latch the meta word, assert s_meta_ready for one cycle, clear the retry count, go to META.
  - META: m_txmeta_valid=1 with the latched word; on ready go to STATUS.
  - STATUS: s_txstatus_ready=1.
    - code 0: go to DATA.
    - code 1 or 3: go to DROP.
    - code 2: if retry count < MAX_RETRIES, increment it and go to BACKOFF; otherwise go to DROP.
  - BACKOFF: wait RETRY_CYCLES cycles, then go to META.
  - DATA: m_tx_* = s_data_* combinationally; m_tx_valid = s_data_valid; s_data_ready = m_tx_ready. On a handshake with last=1: increment pkts_sent, go to IDLE.
  - DROP: s_data_ready=1, m_tx_valid=0. On a beat with last=1: increment pkts_dropped, go to IDLE.
- s_data_ready=0 in every state other than DATA and DROP.
- Counters wrap at 2^32.

## Timing
- Reset values:
  - all valid/ready outputs 0 (s_listen_status_ready and s_txstatus_ready are 0 outside L_STAT/STATUS);
  - m_listen_data 0, m_txmeta_data 0;
  - listen_done 0, counters 0;
  - FSMs in L_WAIT / IDLE.
- Reset mid-operation abandons in-flight packets. Upstream must reset together with this block.
- m_txmeta_valid and m_listen_valid are registered. Once asserted they stay high with stable data until ready.
- Latency, meta accept to m_txmeta_valid: 1 cycle.
- Latency, status code 0 to the first m_tx_valid: 1 cycle if data is present.
- Data path adds zero latency and passes full throughput: one beat per cycle.
- Minimum gap between packets: 3 cycles (IDLE, META, STATUS).
- A status arriving outside STATUS is not accepted (ready=0).
- A meta word arriving while busy is held by its own valid.
- If a counter increment and an overflow happen in the same cycle, the counter wraps to 0.

## Structure
- Shared package tcp_tx_pkg holds:
  - TX and listen state enums;
  - status code constants ST_OK=0, ST_NOCONN=1, ST_NOSPACE=2;
  - meta and status field slice localparams.
- Natural sub-module: tcp_listen_opener, containing the listen FSM and delay counter. The TX FSM stays in the top.

## Test plan
- Start-up: NUM_PORTS=3, all statuses 0x01. Required: listen requests 2888, 2889, 2890, each preceded by a 2^(OPEN_DELAY_BITS-1)-cycle wait, then listen_done=1.
- Listen retry: port 2889 returns 0x00 once. Required: 2889 is re-requested after the delay, then 2890 follows.
- Happy path: meta 0x0040_0005 plus a 1-beat packet, status code 0. Required: m_txmeta_data=0x0040_0005, the beat appears on m_tx_* with last=1, pkts_sent=1.
- No connection: status code 1 on a 3-beat packet. Required: all 3 beats consumed, m_tx_valid never asserted, pkts_dropped=1, and the next packet proceeds normally.
- No space: status code 2 twice, then 0. Required: metadata sent 3 times, at least RETRY_CYCLES apart, then the packet is sent. With MAX_RETRIES+1 consecutive code-2 statuses, the packet is dropped instead.
- Backpressure: toggle m_tx_ready randomly during a 16-beat packet. Required: no beat lost or duplicated, s_data_ready mirrors m_tx_ready.
